// File: rtl/ram_write_arbiter.sv
// Two-requester RAM write-port arbiter with round-robin priority and one-cycle grant latency.
// Define RAM_WRITE_ARBITER_BYPASS_EN to forward just-written data onto colliding read ports.
module ram_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReq0,
  input  logic                  iReq1,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData0,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oAck0,
  output logic                  oAck1,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataIn,
  input  logic [ADDR_WIDTH-1:0] iReadAddress0,
  input  logic [ADDR_WIDTH-1:0] iReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamData0,
  input  logic [DATA_WIDTH-1:0] iRamData1,
  output logic [DATA_WIDTH-1:0] oReadData0,
  output logic [DATA_WIDTH-1:0] oReadData1
);

  typedef enum logic [1:0] {IDLE, WR0, WR1} stateT;

  stateT state;
  stateT nextState;
  logic  pointer;
  logic  started;

  // The first edge after reset release only arms the arbiter, so no grant can land on it.
  always_comb begin
    nextState = IDLE;
    if (started) begin
      if (iReq0 && iReq1) nextState = pointer ? WR1 : WR0;
      else if (iReq0)     nextState = WR0;
      else if (iReq1)     nextState = WR1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= nextState;
      started <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pointer       <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oDataIn       <= '0;
    end else begin
      case (nextState)
        WR0: begin
          pointer       <= 1'b1;
          oWriteEnable  <= 1'b1;
          oWriteAddress <= iAddr0;
          oDataIn       <= iData0;
        end
        WR1: begin
          pointer       <= 1'b0;
          oWriteEnable  <= 1'b1;
          oWriteAddress <= iAddr1;
          oDataIn       <= iData1;
        end
        default: oWriteEnable <= 1'b0;
      endcase
    end
  end

  assign oAck0 = (state == WR0);
  assign oAck1 = (state == WR1);

`ifdef RAM_WRITE_ARBITER_BYPASS_EN
  logic                  bypassWe;
  logic [ADDR_WIDTH-1:0] bypassAddr;
  logic [ADDR_WIDTH-1:0] bypassRdAddr0;
  logic [ADDR_WIDTH-1:0] bypassRdAddr1;
  logic [DATA_WIDTH-1:0] bypassData;

  // Snapshot of the write and reads that met at the last edge; the RAM returned stale data for them.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bypassWe      <= 1'b0;
      bypassAddr    <= '0;
      bypassData    <= '0;
      bypassRdAddr0 <= '0;
      bypassRdAddr1 <= '0;
    end else begin
      bypassWe      <= oWriteEnable;
      bypassAddr    <= oWriteAddress;
      bypassData    <= oDataIn;
      bypassRdAddr0 <= iReadAddress0;
      bypassRdAddr1 <= iReadAddress1;
    end
  end

  assign oReadData0 = (bypassWe && (bypassAddr == bypassRdAddr0)) ? bypassData : iRamData0;
  assign oReadData1 = (bypassWe && (bypassAddr == bypassRdAddr1)) ? bypassData : iRamData1;
`else
  logic unusedReadAddr;

  assign unusedReadAddr = ^{iReadAddress0, iReadAddress1};
  assign oReadData0     = iRamData0;
  assign oReadData1     = iRamData1;
`endif

endmodule

// File: doc/ram_write_arbiter.md
RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, width of write and read data; ADDR_WIDTH, default 8, width of all addresses.
REQ-002 Clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 iReq0, iReq1  input  1 each  write request from requester 0 and requester 1; each SHALL be held high until its ack.
REQ-005 iAddr0, iAddr1  input  ADDR_WIDTH each  write address of each requester, stable while its request is high.
REQ-006 iData0, iData1  input  DATA_WIDTH each  write data of each requester, stable while its request is high.
REQ-007 oAck0, oAck1  output  1 each  one-cycle pulse; high in the cycle the requester's write is presented on the RAM write port.
REQ-008 oWriteEnable  output  1  drives the RAM write-enable input.
REQ-009 oWriteAddress  output  ADDR_WIDTH  drives the RAM write-address input.
REQ-010 oDataIn  output  DATA_WIDTH  drives the RAM write-data input.
REQ-011 iReadAddress0, iReadAddress1  input  ADDR_WIDTH each  read addresses driven to the RAM by the consumer in the same cycle.
REQ-012 iRamData0, iRamData1  input  DATA_WIDTH each  RAM read outputs.
REQ-013 oReadData0, oReadData1  output  DATA_WIDTH each  read data delivered to the consumer.

Function
REQ-014 The FSM SHALL have three states: IDLE (no write issued), WR0 (requester 0 write on port), WR1 (requester 1 write on port).
REQ-015 Next state at each edge: WR0 if only iReq0 is high; WR1 if only iReq1 is high; the priority-pointer requester if both are high; IDLE if neither is high.
REQ-016 The priority pointer SHALL reset to requester 0 and SHALL move to the non-granted requester after every grant.
REQ-017 oWriteEnable, oWriteAddress and oDataIn SHALL be registered. Latency from request sampled to write on port SHALL be 1 cycle.
REQ-018 oWriteEnable SHALL be 1 in WR0/WR1 and 0 in IDLE. In IDLE, oWriteAddress and oDataIn SHALL hold their last values.
REQ-019 oAckN SHALL equal (state == WRN). A requester SHALL treat a request still high in the cycle after its ack as a new request.
REQ-020 The block SHALL sustain one write per cycle. A lone requester holding its request SHALL receive back-to-back grants.
REQ-021 With both requests continuously high, grants SHALL alternate 0,1,0,1. No requester SHALL wait more than 2 cycles from request to ack.
REQ-022 If both requesters target the same address, they SHALL be served in pointer order; the later write's data SHALL remain in the RAM.

Reset
REQ-023 While Reset=0, the block SHALL asynchronously force: state=IDLE, oWriteEnable=0, oAck0=oAck1=0, oWriteAddress=0, oDataIn=0, pointer=requester 0, bypass registers=0.
REQ-024 A grant in progress when Reset asserts SHALL be dropped, with no ack issued. The requester SHALL re-request after release.
REQ-025 After Reset deasserts, the first grant SHALL occur at the second rising edge at the earliest.

Configuration
REQ-026 Macro RAM_WRITE_ARBITER_BYPASS_EN SHALL select read-after-write forwarding.
REQ-027 When the macro is defined, the block SHALL register, at each edge, oWriteEnable, oWriteAddress, oDataIn, iReadAddress0 and iReadAddress1.
REQ-028 When the macro is defined, oReadDataN SHALL equal the registered write data when the registered write enable is 1 and the registered write address equals the registered iReadAddressN; otherwise oReadDataN SHALL equal iRamDataN. This returns new data on a same-cycle read/write collision.
REQ-029 When the macro is undefined, oReadDataN SHALL equal iRamDataN combinationally, no bypass registers SHALL exist, and all ports SHALL remain present.

Verification
REQ-030 Reset mid-grant: iReq0=1, addr 0x05, data 0x1234; assert Reset in the WR0 cycle -> oWriteEnable=0 and oAck0=0 immediately; after release, one write of 0x1234 to 0x05.
REQ-031 Contention: iReq0=iReq1=1 held for 4 cycles after reset -> acks ordered 0,1,0,1; oWriteEnable=1 for all 4 cycles.
REQ-032 Single requester: iReq1=1 for 3 cycles, addr 0x10..0x12 -> 3 consecutive oAck1 pulses; oAck0 stays 0.
REQ-033 Same address: both requesters target 0x07 (data 0xAAAA, 0x5555) with pointer at 0 -> a later read of 0x07 returns 0x5555.
REQ-034 Bypass defined: write 0xBEEF to 0x03 while iReadAddress0=0x03 -> oReadData0=0xBEEF in the next cycle. Same test with the macro undefined -> oReadData0 shows the old RAM value.
REQ-035 Idle hold: after a write to 0x20, drop all requests -> oWriteEnable=0, and oWriteAddress stays 0x20.
